// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce scheduler: per-channel state
// encoding, stability counter width and an index-width helper.
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LO     = 2'd0,
    S_CHK_HI = 2'd1,
    S_HI     = 2'd2,
    S_CHK_LO = 2'd3
  } chan_state_t;

  localparam int CNT_W = 8;

  // Width of an index into n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: four-state FSM plus consecutive-tick counter, advanced
// only on the shared sample tick. The commit strobe is combinational in the tick cycle.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int STABLE = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic sample,
  output logic lvl,
  output logic commit
);

  localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE);

  chan_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             lvl_q, lvl_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lvl_d   = lvl_q;
    commit  = 1'b0;
    cnt_inc = cnt_q + CNT_W'(1);
    if (tick) begin
      unique case (state_q)
        S_LO, S_HI: begin
          if (sample != lvl_q) begin
            // A single differing tick is already enough when STABLE is 1.
            if (STABLE == 1) begin
              commit  = 1'b1;
              lvl_d   = sample;
              cnt_d   = '0;
              state_d = (state_q == S_LO) ? S_HI : S_LO;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = (state_q == S_LO) ? S_CHK_HI : S_CHK_LO;
            end
          end
        end
        S_CHK_HI, S_CHK_LO: begin
          if (sample == lvl_q) begin
            cnt_d   = '0;
            state_d = (state_q == S_CHK_HI) ? S_LO : S_HI;
          end else if (cnt_inc == STABLE_CNT) begin
            commit  = 1'b1;
            lvl_d   = sample;
            cnt_d   = '0;
            state_d = (state_q == S_CHK_HI) ? S_HI : S_LO;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = S_LO;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LO;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
    end
  end

  assign lvl = lvl_q;

endmodule

// File: rtl/debounce_sched.sv
// Multi-channel debouncer with a shared tick prescaler and a round-robin event
// output register. Define DEBOUNCE_SCHED_SYNC_EN to add a two-flop input synchronizer.
module debounce_sched
  import debounce_pkg::*;
#(
  parameter  int NCH     = 4,
  parameter  int FREQ    = 125,
  parameter  int TICK_US = 1000,
  parameter  int STABLE  = 10,
  localparam int CH_W    = idx_width(NCH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH-1:0]  i_sig,
  output logic [NCH-1:0]  o_lvl,
  output logic            o_ev_valid,
  input  logic            i_ev_ready,
  output logic [CH_W-1:0] o_ev_ch,
  output logic            o_ev_lvl,
  output logic [NCH-1:0]  o_ovf,
  input  logic            i_ovf_clr
);

  localparam int              TICKS      = FREQ * TICK_US;
  localparam int              PW         = idx_width(TICKS);
  localparam logic [PW-1:0]   PRESC_TERM = PW'(TICKS - 1);
  localparam logic [CH_W-1:0] RR_INIT    = CH_W'(NCH - 1);

  logic [PW-1:0]   presc_q, presc_d;
  logic            tick;
  logic [NCH-1:0]  samp;
  logic [NCH-1:0]  lvl, commit;
  logic [NCH-1:0]  pend_q, pend_d, plvl_q, plvl_d, ovf_q, ovf_d, grant;
  logic            ev_valid_q, ev_valid_d, ev_lvl_q, ev_lvl_d;
  logic [CH_W-1:0] ev_ch_q, ev_ch_d, rr_q, rr_d;
  logic            load, found;
  int              idx;

  assign tick    = (presc_q == PRESC_TERM);
  assign presc_d = tick ? '0 : presc_q + PW'(1);

`ifdef DEBOUNCE_SCHED_SYNC_EN
  logic [NCH-1:0] sync1_q, sync2_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= i_sig;
      sync2_q <= sync1_q;
    end
  end
  assign samp = sync2_q;
`else
  assign samp = i_sig;
`endif

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    debounce_chan #(
      .STABLE (STABLE)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .sample (samp[gi]),
      .lvl    (lvl[gi]),
      .commit (commit[gi])
    );
  end

  // Grants come from the registered pending set, so a commit landing in the
  // same cycle as its channel's grant stays queued behind the older event.
  always_comb begin
    load       = !ev_valid_q || i_ev_ready;
    found      = 1'b0;
    grant      = '0;
    idx        = 0;
    rr_d       = rr_q;
    ev_valid_d = ev_valid_q;
    ev_ch_d    = ev_ch_q;
    ev_lvl_d   = ev_lvl_q;
    if (load) begin
      ev_valid_d = 1'b0;
      for (int k = 1; k <= NCH; k++) begin
        idx = (int'(rr_q) + k) % NCH;
        if (!found && pend_q[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          rr_d       = CH_W'(idx);
          ev_ch_d    = CH_W'(idx);
          ev_lvl_d   = plvl_q[idx];
          ev_valid_d = 1'b1;
        end
      end
    end
    pend_d = (pend_q & ~grant) | commit;
    plvl_d = (plvl_q & ~commit) | (~lvl & commit);
    ovf_d  = (i_ovf_clr ? '0 : ovf_q) | (commit & pend_q & ~grant);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q    <= '0;
      pend_q     <= '0;
      plvl_q     <= '0;
      ovf_q      <= '0;
      ev_valid_q <= 1'b0;
      ev_ch_q    <= '0;
      ev_lvl_q   <= 1'b0;
      rr_q       <= RR_INIT;
    end else begin
      presc_q    <= presc_d;
      pend_q     <= pend_d;
      plvl_q     <= plvl_d;
      ovf_q      <= ovf_d;
      ev_valid_q <= ev_valid_d;
      ev_ch_q    <= ev_ch_d;
      ev_lvl_q   <= ev_lvl_d;
      rr_q       <= rr_d;
    end
  end

  assign o_lvl      = lvl;
  assign o_ev_valid = ev_valid_q;
  assign o_ev_ch    = ev_ch_q;
  assign o_ev_lvl   = ev_lvl_q;
  assign o_ovf      = ovf_q;

endmodule

// File: tb/tb_debounce_sched.sv
// Self-checking bench for debounce_sched: directed scenarios plus a randomized
// run scored against a tick-level debounce model and per-channel event queue.
module tb_debounce_sched;

  localparam int NCH     = 4;
  localparam int FREQ    = 125;
  localparam int TICK_US = 1;
  localparam int STABLE  = 4;
  localparam int TPER    = FREQ * TICK_US;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] i_sig = 4'b0;
  logic       i_ev_ready = 1'b0;
  logic       i_ovf_clr = 1'b0;
  logic [3:0] o_lvl;
  logic [3:0] o_ovf;
  logic       o_ev_valid;
  logic       o_ev_lvl;
  logic [1:0] o_ev_ch;

  always #5 clk = ~clk;

  debounce_sched #(
    .NCH     (NCH),
    .FREQ    (FREQ),
    .TICK_US (TICK_US),
    .STABLE  (STABLE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_sig      (i_sig),
    .o_lvl      (o_lvl),
    .o_ev_valid (o_ev_valid),
    .i_ev_ready (i_ev_ready),
    .o_ev_ch    (o_ev_ch),
    .o_ev_lvl   (o_ev_lvl),
    .o_ovf      (o_ovf),
    .i_ovf_clr  (i_ovf_clr)
  );

  typedef struct {
    int cyc;
    int ch;
    int lvl;
  } ev_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc;
  int         tick_cnt;
  logic [3:0] m_lvl;
  int         m_run [NCH];
  logic [3:0] h1, h2;
  bit         sb_en;
  logic [2:0] expq [$];
  ev_t        obs [$];

  // One clock: model the tick from the pre-edge sample, record handshakes, check after edge.
  task automatic step();
    logic [3:0] s;
    bit tick_now, hs, hold;
    int pch, plvl, f;
    tick_now = (cyc % TPER) == (TPER - 1);
`ifdef DEBOUNCE_SCHED_SYNC_EN
    s = h2;
`else
    s = i_sig;
`endif
    hs   = o_ev_valid && i_ev_ready;
    hold = o_ev_valid && !i_ev_ready;
    pch  = int'(o_ev_ch);
    plvl = int'(o_ev_lvl);
    @(posedge clk);
    h2 = h1;
    h1 = i_sig;
    #1;
    cyc++;
    if (hs) begin
      obs.push_back('{cyc, pch, plvl});
      if (sb_en) begin
        f = -1;
        foreach (expq[j]) if (f < 0 && expq[j][2:1] == pch[1:0]) f = j;
        n_tests++;
        if (f < 0) begin
          n_fail++;
          $display("FAIL sb_event: got event ch=%0d lvl=%0d at cycle %0d, required none outstanding", pch, plvl, cyc);
        end else begin
          if (expq[f][0] !== plvl[0]) begin
            n_fail++;
            $display("FAIL sb_level: ch=%0d got lvl=%0d, required %0d", pch, plvl, expq[f][0]);
          end
          expq.delete(f);
        end
      end
    end
    if (tick_now) begin
      tick_cnt++;
      for (int c = 0; c < NCH; c++) begin
        if (s[c] != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == STABLE) begin
            m_lvl[c] = s[c];
            m_run[c] = 0;
            if (sb_en) expq.push_back({2'(c), s[c]});
          end
        end else begin
          m_run[c] = 0;
        end
      end
    end
    n_tests++;
    if (o_lvl !== m_lvl) begin
      n_fail++;
      $display("FAIL o_lvl: cycle %0d got %b, required %b", cyc, o_lvl, m_lvl);
    end
    if (hold) begin
      n_tests++;
      if (o_ev_valid !== 1'b1 || o_ev_ch !== pch[1:0] || o_ev_lvl !== plvl[0]) begin
        n_fail++;
        $display("FAIL hold: cycle %0d got v=%b ch=%0d lvl=%b, required v=1 ch=%0d lvl=%0d",
                 cyc, o_ev_valid, o_ev_ch, o_ev_lvl, pch, plvl);
      end
    end
  endtask

  task automatic do_reset(input logic [3:0] sig_during);
    rst   = 1'b1;
    i_sig = sig_during;
    repeat (3) @(posedge clk);
    m_lvl    = '0;
    for (int c = 0; c < NCH; c++) m_run[c] = 0;
    h1       = '0;
    h2       = '0;
    cyc      = 0;
    tick_cnt = 0;
    expq.delete();
    obs.delete();
    #1 rst = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    int tgt;
    tgt = tick_cnt + n;
    while (tick_cnt < tgt) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    n_tests++;
    if (o_lvl !== 4'b0 || o_ev_valid !== 1'b0 || o_ev_ch !== 2'd0 || o_ev_lvl !== 1'b0 || o_ovf !== 4'b0) begin
      n_fail++;
      $display("FAIL %s: got lvl=%b v=%b ch=%0d elvl=%b ovf=%b, required all zero",
               tag, o_lvl, o_ev_valid, o_ev_ch, o_ev_lvl, o_ovf);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
  endtask

  task automatic test_single();
    int rise;
    i_ev_ready = 1'b1;
    do_reset(4'b0001);
    rise = -1;
    while (tick_cnt < 6) begin
      step();
      if (rise < 0 && o_lvl[0] === 1'b1) rise = cyc;
    end
    n_tests++;
    if (rise != 4 * TPER) begin
      n_fail++;
      $display("FAIL single_rise: o_lvl[0] rose at cycle %0d, required %0d", rise, 4 * TPER);
    end
    n_tests++;
    if (obs.size() != 1 || obs[0].ch != 0 || obs[0].lvl != 1) begin
      n_fail++;
      $display("FAIL single_event: got %0d events, required exactly one (ch 0, lvl 1)", obs.size());
    end else begin
      n_tests++;
      if (obs[0].cyc != 4 * TPER + 2) begin
        n_fail++;
        $display("FAIL single_latency: handshake at cycle %0d, required %0d", obs[0].cyc, 4 * TPER + 2);
      end
    end
  endtask

  task automatic test_glitch();
    i_ev_ready = 1'b1;
    do_reset(4'b0000);
    run_ticks(1);
    i_sig[1] = 1'b1;
    run_ticks(2);
    i_sig[1] = 1'b0;
    run_ticks(2);
    i_sig[2] = 1'b1;
    run_ticks(STABLE - 1);
    i_sig[2] = 1'b0;
    run_ticks(STABLE + 1);
    n_tests++;
    if (o_lvl !== 4'b0 || obs.size() != 0) begin
      n_fail++;
      $display("FAIL glitch: got o_lvl=%b with %0d events, required 0000 and none", o_lvl, obs.size());
    end
  endtask

  task automatic test_all_rise();
    i_ev_ready = 1'b1;
    do_reset(4'b0000);
    repeat (3) step();
    i_sig = 4'hF;
    run_ticks(5);
    n_tests++;
    if (obs.size() != 4) begin
      n_fail++;
      $display("FAIL all_rise_count: got %0d events, required 4", obs.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (obs[i].ch != i || obs[i].lvl != 1 || obs[i].cyc != obs[0].cyc + i) begin
          n_fail++;
          $display("FAIL all_rise_ev%0d: got ch=%0d lvl=%0d cyc=%0d, required ch=%0d lvl=1 cyc=%0d",
                   i, obs[i].ch, obs[i].lvl, obs[i].cyc, i, obs[0].cyc + i);
        end
      end
    end
  endtask

  task automatic test_ovf();
    i_ev_ready = 1'b0;
    do_reset(4'b0000);
    step();
    i_sig[2] = 1'b1;
    run_ticks(STABLE);
    repeat (3) step();
    n_tests++;
    if (o_ev_valid !== 1'b1 || o_ev_ch !== 2'd2 || o_ev_lvl !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_held: got v=%b ch=%0d lvl=%b, required v=1 ch=2 lvl=1", o_ev_valid, o_ev_ch, o_ev_lvl);
    end
    i_sig[2] = 1'b0;
    run_ticks(STABLE);
    step();
    n_tests++;
    if (o_ovf !== 4'b0) begin
      n_fail++;
      $display("FAIL ovf_no_overflow: got o_ovf=%b, required 0000", o_ovf);
    end
    // Clear held active across the overflowing commit: the set must win.
    i_ovf_clr = 1'b1;
    i_sig[2]  = 1'b1;
    run_ticks(STABLE);
    i_ovf_clr = 1'b0;
    repeat (2) step();
    n_tests++;
    if (o_ovf !== 4'b0100) begin
      n_fail++;
      $display("FAIL ovf_set: got o_ovf=%b, required 0100", o_ovf);
    end
    i_ev_ready = 1'b1;
    repeat (4) step();
    n_tests++;
    if (obs.size() != 2 || obs[0].ch != 2 || obs[0].lvl != 1 || obs[1].ch != 2 || obs[1].lvl != 1) begin
      n_fail++;
      $display("FAIL ovf_events: got %0d events, required (2,1),(2,1)", obs.size());
    end
    n_tests++;
    if (o_ev_valid !== 1'b0 || o_ovf !== 4'b0100) begin
      n_fail++;
      $display("FAIL ovf_drain: got v=%b ovf=%b, required v=0 ovf=0100", o_ev_valid, o_ovf);
    end
    i_ovf_clr = 1'b1;
    step();
    i_ovf_clr = 1'b0;
    n_tests++;
    if (o_ovf !== 4'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got o_ovf=%b, required 0000", o_ovf);
    end
  endtask

  task automatic test_reset_mid();
    i_ev_ready = 1'b0;
    do_reset(4'b0000);
    step();
    i_sig[0] = 1'b1;
    run_ticks(STABLE);
    repeat (3) step();
    n_tests++;
    if (o_ev_valid !== 1'b1 || o_ev_ch !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_held: got v=%b ch=%0d, required v=1 ch=0", o_ev_valid, o_ev_ch);
    end
    i_sig[3] = 1'b1;
    run_ticks(STABLE - 1);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("mid_async_reset");
    do_reset(4'b1001);
    i_ev_ready = 1'b1;
    run_ticks(STABLE + 2);
    n_tests++;
    if (obs.size() != 2 || obs[0].ch != 0 || obs[0].lvl != 1 || obs[1].ch != 3 || obs[1].lvl != 1) begin
      n_fail++;
      $display("FAIL mid_events: got %0d events, required (0,1),(3,1)", obs.size());
    end
  endtask

  task automatic test_random();
    int b;
    do_reset(4'b0000);
    sb_en = 1'b1;
    for (int n = 0; n < 12000; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        b = int'($urandom_range(0, 3));
        i_sig[b] = ~i_sig[b];
      end
      i_ev_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    i_ev_ready = 1'b1;
    repeat (10) step();
    sb_en = 1'b0;
    n_tests++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL random_drain: %0d committed events never delivered, required 0", expq.size());
    end
    n_tests++;
    if (o_ovf !== 4'b0) begin
      n_fail++;
      $display("FAIL random_ovf: got o_ovf=%b, required 0000", o_ovf);
    end
  endtask

  initial begin
    sb_en    = 1'b0;
    cyc      = 0;
    tick_cnt = 0;
    m_lvl    = '0;
    h1       = '0;
    h2       = '0;
    for (int c = 0; c < NCH; c++) m_run[c] = 0;
    test_reset();
    test_single();
    test_glitch();
    test_all_rise();
    test_ovf();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
